// File: rtl/rv32_pkg.sv
`timescale 1ns/1ps
// rv32_pkg: shared constants and helpers for the rv32_core slice.
//   - RV32I opcode / funct3 / funct7 encodings
//   - machine CSR addresses and trap cause codes
//   - ALU operation enum plus decode and execute helpers
package rv32_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_REG     = 7'b0110011;
    localparam logic [6:0] OP_MISCMEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // SYSTEM funct3 0 selects ECALL/EBREAK/xRET/WFI by imm field
    localparam logic [2:0]  F3_PRIV   = 3'b000;
    localparam logic [11:0] SYS_ECALL  = 12'h000;
    localparam logic [11:0] SYS_EBREAK = 12'h001;
    localparam logic [11:0] SYS_MRET   = 12'h302;
    localparam logic [11:0] SYS_SRET   = 12'h102;

    // funct7 selecting SUB / SRA
    localparam logic [6:0] F7_ALT = 7'b0100000;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    // Trap causes
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // alt is instr[30] where it distinguishes SUB/SRA
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu_exec(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

endpackage

// File: rtl/rv32_memory.sv
`timescale 1ns/1ps
// rv32_memory: unified instruction/data word memory.
//   clk    - write clock
//   iaddr  - fetch byte address, combinational read to idata
//   daddr  - data byte address, combinational read to ddata, also write address
//   be     - per-byte write enables (lane i = bits [8i+7:8i])
//   wdata  - write data, already replicated onto the enabled lanes
// Word index is addr[AW+1:2]; lower address bits are ignored.
module rv32_memory #(
    parameter int MEM_WORDS = 65536
) (
    input  logic        clk,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    input  logic [31:0] daddr,
    output logic [31:0] ddata,
    input  logic [3:0]  be,
    input  logic [31:0] wdata
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   m [0:MEM_WORDS-1];
    logic [AW-1:0] iidx;
    logic [AW-1:0] didx;
    logic          unused_addr_bits;

    assign iidx  = iaddr[AW+1:2];
    assign didx  = daddr[AW+1:2];
    assign idata = m[iidx];
    assign ddata = m[didx];

    assign unused_addr_bits = ^{iaddr[31:AW+2], iaddr[1:0], daddr[31:AW+2], daddr[1:0]};

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[didx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

endmodule

// File: rtl/rv32_core.sv
`timescale 1ns/1ps
// rv32_core: single-cycle RV32I + Zicsr core with ECALL/EBREAK/MRET traps and
// an embedded unified memory (instance "memory"). One instruction retires per clock.
//   clk - system clock, all state updates on the rising edge
//   rst - asynchronous active-low reset (0 = reset, 1 = run)
// Optional build macro RV32_CORE_COUNTERS_EN: cycle/instret counters at
// CSR 0xC00/0xC80 and 0xC02/0xC82 (read-only). Without it those are plain storage.
module rv32_core
    import rv32_pkg::*;
#(
    parameter int          MEM_WORDS = 65536,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic clk,
    input  logic rst
);
    logic [31:0] if_pc;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    // Decode fields
    logic [31:0] instr;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rv1, rv2, pc_plus4;

    assign opcode = instr[6:0];
    assign rd_a   = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1_a  = instr[19:15];
    assign rs2_a  = instr[24:20];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rv1      = (rs1_a == 5'd0) ? 32'd0 : rs[rs1_a];
    assign rv2      = (rs2_a == 5'd0) ? 32'd0 : rs[rs2_a];
    assign pc_plus4 = if_pc + 32'd4;

    // ALU: operand B is the immediate for OP-IMM; instr[30] only means SRAI there
    alu_op_e     alu_op;
    logic        alu_alt;
    logic [31:0] alu_b, alu_y;

    assign alu_alt = (opcode == OP_REG) ? (f7 == F7_ALT) : (f3 == F3_SR && instr[30]);
    assign alu_op  = alu_decode(f3, alu_alt);
    assign alu_b   = (opcode == OP_IMM) ? imm_i : rv2;
    assign alu_y   = alu_exec(alu_op, rv1, alu_b);

    // Data path to memory
    logic [31:0] data_addr, ddata, ld_shift;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [3:0]  st_be, mem_be;
    logic [31:0] st_data;

    assign data_addr = (opcode == OP_STORE) ? rv1 + imm_s : rv1 + imm_i;
    assign ld_shift  = ddata >> {data_addr[1:0], 3'b000};
    assign ld_byte   = ld_shift[7:0];
    assign ld_half   = data_addr[1] ? ddata[31:16] : ddata[15:0];
    // No stores while held in reset so a preloaded image is never disturbed
    assign mem_be    = rst ? st_be : 4'b0000;

    rv32_memory #(.MEM_WORDS(MEM_WORDS)) memory (
        .clk   (clk),
        .iaddr (if_pc),
        .idata (instr),
        .daddr (data_addr),
        .ddata (ddata),
        .be    (mem_be),
        .wdata (st_data)
    );

    // Branch condition
    logic br_taken;
    always_comb begin
        case (f3)
            F3_BEQ:  br_taken = (rv1 == rv2);
            F3_BNE:  br_taken = (rv1 != rv2);
            F3_BLT:  br_taken = ($signed(rv1) < $signed(rv2));
            F3_BGE:  br_taken = ($signed(rv1) >= $signed(rv2));
            F3_BLTU: br_taken = (rv1 < rv2);
            F3_BGEU: br_taken = (rv1 >= rv2);
            default: br_taken = 1'b0;
        endcase
    end

    // CSR access
    logic [11:0] csr_a;
    logic [31:0] csr_old, csr_src;
    assign csr_a   = instr[31:20];
    assign csr_old = csr[csr_a];
    assign csr_src = f3[2] ? {27'd0, rs1_a} : rv1;

    // Main decode / execute
    logic [31:0] next_pc, rd_val, csr_wval, trap_cause;
    logic        rd_we, csr_we, trap, mret;

    always_comb begin
        next_pc    = pc_plus4;
        rd_we      = 1'b0;
        rd_val     = alu_y;
        st_be      = 4'b0000;
        st_data    = rv2;
        csr_we     = 1'b0;
        csr_wval   = 32'd0;
        trap       = 1'b0;
        trap_cause = 32'd0;
        mret       = 1'b0;
        case (opcode)
            OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
            OP_AUIPC:  begin rd_we = 1'b1; rd_val = if_pc + imm_u; end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                next_pc = if_pc + imm_j;
            end
            OP_JALR: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                next_pc = (rv1 + imm_i) & ~32'd1;
            end
            OP_BRANCH: if (br_taken) next_pc = if_pc + imm_b;
            OP_LOAD: begin
                rd_we = 1'b1;
                case (f3)
                    F3_B:    rd_val = {{24{ld_byte[7]}}, ld_byte};
                    F3_H:    rd_val = {{16{ld_half[15]}}, ld_half};
                    F3_W:    rd_val = ddata;
                    F3_BU:   rd_val = {24'd0, ld_byte};
                    F3_HU:   rd_val = {16'd0, ld_half};
                    default: rd_we  = 1'b0;
                endcase
            end
            OP_STORE: begin
                case (f3)
                    F3_B: begin st_be = 4'b0001 << data_addr[1:0]; st_data = {4{rv2[7:0]}}; end
                    F3_H: begin
                        st_be   = data_addr[1] ? 4'b1100 : 4'b0011;
                        st_data = {2{rv2[15:0]}};
                    end
                    F3_W:    st_be = 4'b1111;
                    default: st_be = 4'b0000;
                endcase
            end
            OP_IMM, OP_REG: rd_we = 1'b1;
            OP_SYSTEM: begin
                if (f3 == F3_PRIV) begin
                    case (csr_a)
                        SYS_ECALL:  begin trap = 1'b1; trap_cause = CAUSE_ECALL_M; end
                        SYS_EBREAK: begin trap = 1'b1; trap_cause = CAUSE_BREAKPOINT; end
                        SYS_MRET:   begin mret = 1'b1; next_pc = csr[CSR_MEPC]; end
                        SYS_SRET:   next_pc = csr[CSR_MEPC];
                        default:    ;  // WFI and others retire as NOPs
                    endcase
                end else if (f3 != 3'b100) begin
                    rd_we  = 1'b1;
                    rd_val = csr_old;
                    // Set/clear with a zero source leaves the CSR unwritten
                    case (f3[1:0])
                        2'b01:   begin csr_we = 1'b1; csr_wval = csr_src; end
                        2'b10:   begin csr_we = (rs1_a != 5'd0); csr_wval = csr_old | csr_src; end
                        default: begin csr_we = (rs1_a != 5'd0); csr_wval = csr_old & ~csr_src; end
                    endcase
                end
            end
            default: ;  // FENCE/FENCE.I and unknown opcodes: NOP, pc+4
        endcase
        if (trap) next_pc = {csr[CSR_MTVEC][31:2], 2'b00};
    end

    // PC and register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_pc <= RESET_PC;
            for (int i = 0; i < 32; i++) rs[i] <= 32'd0;
        end else begin
            if_pc <= next_pc;
            if (rd_we && rd_a != 5'd0) rs[rd_a] <= rd_val;
        end
    end

    // CSR file. Counter updates come last so they win over any CSR write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csr[CSR_MSTATUS] <= 32'd0;
            csr[CSR_MTVEC]   <= 32'd0;
            csr[CSR_MEPC]    <= 32'd0;
            csr[CSR_MCAUSE]  <= 32'd0;
`ifdef RV32_CORE_COUNTERS_EN
            csr[CSR_CYCLE]    <= 32'd0;
            csr[CSR_CYCLEH]   <= 32'd0;
            csr[CSR_INSTRET]  <= 32'd0;
            csr[CSR_INSTRETH] <= 32'd0;
`endif
        end else begin
            if (trap) begin
                csr[CSR_MEPC]    <= if_pc;
                csr[CSR_MCAUSE]  <= trap_cause;
                // MPIE <= MIE, MIE <= 0
                csr[CSR_MSTATUS] <= {csr[CSR_MSTATUS][31:8], csr[CSR_MSTATUS][3],
                                     csr[CSR_MSTATUS][6:4], 1'b0, csr[CSR_MSTATUS][2:0]};
            end else if (mret) begin
                // MIE <= MPIE, MPIE <= 1
                csr[CSR_MSTATUS] <= {csr[CSR_MSTATUS][31:8], 1'b1,
                                     csr[CSR_MSTATUS][6:4], csr[CSR_MSTATUS][7],
                                     csr[CSR_MSTATUS][2:0]};
            end else if (csr_we) begin
                csr[csr_a] <= csr_wval;
            end
`ifdef RV32_CORE_COUNTERS_EN
            {csr[CSR_CYCLEH], csr[CSR_CYCLE]} <= {csr[CSR_CYCLEH], csr[CSR_CYCLE]} + 64'd1;
            {csr[CSR_INSTRETH], csr[CSR_INSTRET]} <=
                {csr[CSR_INSTRETH], csr[CSR_INSTRET]} + {63'd0, ~trap};
`endif
        end
    end

endmodule

// File: tb/tb_rv32_core.sv
`timescale 1ns/1ps
// tb_rv32_core: directed programs for rv32_core, checked with immediate assertions.
module tb_rv32_core;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32_core dut (.clk(clk), .rst(rst));

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67;
    localparam logic [6:0] LOAD = 7'h03, IMM = 7'h13, SYS = 7'h73;

    // Instruction encoders
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Scoreboard compare
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic begin_prog();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) dut.memory.m[i] = 32'h0000_0013;
    endtask
    task automatic poke(input logic [31:0] addr, input logic [31:0] w);
        dut.memory.m[addr[17:2]] = w;
    endtask
    task automatic go();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.rs[i], 32'd0);
    endtask

    initial begin
        // ---------- Program 1: reset state, ALU and taken branch ----------
        begin_prog();
        poke(32'h00, enc_i(12'd5,   5'd0, 3'b000, 5'd1, IMM));
        poke(32'h04, enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, IMM));
        poke(32'h08, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
        poke(32'h0C, enc_b(13'd8, 5'd3, 5'd3, 3'b000));
        poke(32'h10, enc_i(12'd1, 5'd0, 3'b000, 5'd4, IMM));
        poke(32'h14, enc_i(12'd7, 5'd0, 3'b000, 5'd5, IMM));
        poke(32'h18, enc_i(12'd9, 5'd0, 3'b000, 5'd0, IMM));
        poke(32'h1C, enc_j(21'd0, 5'd0));
        go();
        check("rst_pc", dut.if_pc, 32'h0);
        check("rst_mcause", dut.csr[12'h342], 32'd0);
        check_regs_zero("rst");
        step(1);
        check("p1_pc_4", dut.if_pc, 32'h4);
        check("p1_x1", dut.rs[1], 32'd5);
        step(2);
        check("p1_pc_c", dut.if_pc, 32'hC);
        check("p1_x2", dut.rs[2], 32'hFFFF_FFFD);
        check("p1_x3", dut.rs[3], 32'd2);
        step(1);
        check("p1_beq_taken", dut.if_pc, 32'h14);
        step(1);
        check("p1_x5", dut.rs[5], 32'd7);
        step(4);
        check("p1_loop_pc", dut.if_pc, 32'h1C);
        check("p1_x4_skipped", dut.rs[4], 32'd0);
        check("p1_x0_zero", dut.rs[0], 32'd0);

        // ---------- Program 2: ALU ops, shifts, compares, jumps ----------
        begin_prog();
        poke(32'h00, enc_u(20'h80000, 5'd1, LUI));
        poke(32'h04, enc_i(12'hFFF, 5'd0, 3'b000, 5'd2, IMM));
        poke(32'h08, enc_i(12'h404, 5'd1, 3'b101, 5'd3, IMM));
        poke(32'h0C, enc_i(12'h004, 5'd1, 3'b101, 5'd4, IMM));
        poke(32'h10, enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd5));
        poke(32'h14, enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd6));
        poke(32'h18, enc_r(7'h20, 5'd2, 5'd0, 3'b000, 5'd7));
        poke(32'h1C, enc_i(12'h0F0, 5'd2, 3'b100, 5'd8, IMM));
        poke(32'h20, enc_i(12'd35, 5'd0, 3'b000, 5'd10, IMM));
        poke(32'h24, enc_r(7'h00, 5'd10, 5'd7, 3'b001, 5'd9));
        poke(32'h28, enc_u(20'h00001, 5'd11, AUIPC));
        poke(32'h2C, enc_r(7'h20, 5'd10, 5'd2, 3'b101, 5'd12));
        poke(32'h30, enc_b(13'd8, 5'd7, 5'd7, 3'b001));
        poke(32'h34, enc_b(13'd8, 5'd7, 5'd1, 3'b100));
        poke(32'h38, enc_i(12'd1, 5'd0, 3'b000, 5'd13, IMM));
        poke(32'h3C, enc_j(21'd8, 5'd14));
        poke(32'h40, enc_i(12'd2, 5'd0, 3'b000, 5'd13, IMM));
        poke(32'h44, enc_i(12'h050, 5'd0, 3'b000, 5'd15, IMM));
        poke(32'h48, enc_i(12'h001, 5'd15, 3'b000, 5'd16, JALR));
        poke(32'h4C, enc_i(12'd3, 5'd0, 3'b000, 5'd13, IMM));
        poke(32'h50, enc_r(7'h00, 5'd7, 5'd1, 3'b110, 5'd17));
        poke(32'h54, enc_j(21'd0, 5'd0));
        go();
        step(13);
        check("p2_bne_not_taken", dut.if_pc, 32'h34);
        step(1);
        check("p2_blt_taken", dut.if_pc, 32'h3C);
        step(1);
        check("p2_jal_target", dut.if_pc, 32'h44);
        step(2);
        check("p2_jalr_target", dut.if_pc, 32'h50);
        step(4);
        check("p2_loop_pc", dut.if_pc, 32'h54);
        exp_q = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hF800_0000, 32'h0800_0000,
                  32'h1, 32'h1, 32'h1, 32'hFFFF_FF0F, 32'h8, 32'h23,
                  32'h1028, 32'hFFFF_FFFF, 32'h0, 32'h40, 32'h50, 32'h4C, 32'h8000_0001};
        for (int i = 1; i <= 17; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check($sformatf("p2_x%0d", i), dut.rs[i], e);
        end

        // ---------- Program 3: loads and stores ----------
        begin_prog();
        poke(32'h00, enc_u(20'h12345, 5'd1, LUI));
        poke(32'h04, enc_i(12'h678, 5'd1, 3'b000, 5'd1, IMM));
        poke(32'h08, enc_i(12'h100, 5'd0, 3'b000, 5'd2, IMM));
        poke(32'h0C, enc_s(12'd0, 5'd1, 5'd2, 3'b010));
        poke(32'h10, enc_i(12'd1, 5'd2, 3'b000, 5'd3, LOAD));
        poke(32'h14, enc_i(12'd2, 5'd2, 3'b101, 5'd4, LOAD));
        poke(32'h18, enc_i(12'hFAA, 5'd0, 3'b000, 5'd5, IMM));
        poke(32'h1C, enc_s(12'd3, 5'd5, 5'd2, 3'b000));
        poke(32'h20, enc_i(12'd3, 5'd2, 3'b000, 5'd6, LOAD));
        poke(32'h24, enc_i(12'd2, 5'd2, 3'b001, 5'd7, LOAD));
        poke(32'h28, enc_i(12'd3, 5'd2, 3'b100, 5'd8, LOAD));
        poke(32'h2C, enc_s(12'd0, 5'd5, 5'd2, 3'b001));
        poke(32'h30, enc_i(12'd0, 5'd2, 3'b010, 5'd9, LOAD));
        poke(32'h34, enc_j(21'd0, 5'd0));
        go();
        step(8);
        check("p3_pc", dut.if_pc, 32'h20);
        check("p3_lb_0x101", dut.rs[3], 32'h0000_0056);
        check("p3_lhu_0x102", dut.rs[4], 32'h0000_1234);
        check("p3_mem_after_sb", dut.memory.m[16'h40], 32'hAA34_5678);
        step(5);
        check("p3_pc_end", dut.if_pc, 32'h34);
        check("p3_lb_neg", dut.rs[6], 32'hFFFF_FFAA);
        check("p3_lh_neg", dut.rs[7], 32'hFFFF_AA34);
        check("p3_lbu", dut.rs[8], 32'h0000_00AA);
        check("p3_lw_after_sh", dut.rs[9], 32'hAA34_FFAA);
        check("p3_mem_after_sh", dut.memory.m[16'h40], 32'hAA34_FFAA);

        // ---------- Program 4: CSR ops, ECALL/EBREAK/MRET, pass loop ----------
        begin_prog();
        poke(32'h00, enc_i(12'h080, 5'd0, 3'b000, 5'd6, IMM));
        poke(32'h04, enc_i(12'h305, 5'd6, 3'b001, 5'd5, SYS));
        poke(32'h08, enc_i(12'h305, 5'd0, 3'b010, 5'd7, SYS));
        poke(32'h0C, enc_i(12'd8, 5'd0, 3'b000, 5'd9, IMM));
        poke(32'h10, enc_i(12'h300, 5'd9, 3'b010, 5'd0, SYS));
        poke(32'h14, enc_i(12'h340, 5'd5, 3'b101, 5'd10, SYS));
        poke(32'h18, enc_i(12'h340, 5'd1, 3'b111, 5'd11, SYS));
        poke(32'h1C, enc_i(12'h340, 5'd0, 3'b110, 5'd12, SYS));
        poke(32'h20, 32'h0000_0073);
        poke(32'h24, enc_i(12'd1, 5'd0, 3'b000, 5'd3, IMM));
        poke(32'h28, 32'h0010_0073);
        poke(32'h2C, enc_j(21'h18, 5'd0));
        poke(32'h44, enc_j(21'd0, 5'd0));
        poke(32'h80, enc_i(12'h341, 5'd0, 3'b010, 5'd20, SYS));
        poke(32'h84, enc_i(12'd4, 5'd20, 3'b000, 5'd20, IMM));
        poke(32'h88, enc_i(12'h341, 5'd20, 3'b001, 5'd0, SYS));
        poke(32'h8C, 32'h3020_0073);
        go();
        step(8);
        check("p4_pc_ecall", dut.if_pc, 32'h20);
        check("p4_csrrw_old", dut.rs[5], 32'd0);
        check("p4_mtvec", dut.csr[12'h305], 32'h80);
        check("p4_csrrs_read", dut.rs[7], 32'h80);
        check("p4_mstatus_set", dut.csr[12'h300], 32'h8);
        check("p4_csrrwi_old", dut.rs[10], 32'd0);
        check("p4_csrrci_old", dut.rs[11], 32'd5);
        check("p4_csrrsi_old", dut.rs[12], 32'd4);
        check("p4_mscratch", dut.csr[12'h340], 32'd4);
        step(1);
        check("p4_trap_pc", dut.if_pc, 32'h80);
        check("p4_mepc", dut.csr[12'h341], 32'h20);
        check("p4_mcause_ecall", dut.csr[12'h342], 32'd11);
        check("p4_mstatus_trap", dut.csr[12'h300], 32'h80);
        step(4);
        check("p4_mret_pc", dut.if_pc, 32'h24);
        check("p4_mstatus_mret", dut.csr[12'h300], 32'h88);
        step(2);
        check("p4_ebreak_pc", dut.if_pc, 32'h80);
        check("p4_mcause_ebreak", dut.csr[12'h342], 32'd3);
        check("p4_mepc_ebreak", dut.csr[12'h341], 32'h28);
        begin
            int cyc = 0;
            while (dut.if_pc !== 32'h44 && cyc < 6000) begin
                step(1);
                cyc++;
            end
        end
        check("p4_pass_pc", dut.if_pc, 32'h44);
        check("p4_pass_x3", dut.rs[3], 32'd1);

        // ---------- Asynchronous reset mid-run ----------
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst2_pc", dut.if_pc, 32'h0);
        check("rst2_mstatus", dut.csr[12'h300], 32'd0);
        check("rst2_mtvec", dut.csr[12'h305], 32'd0);
        check("rst2_mepc", dut.csr[12'h341], 32'd0);
        check("rst2_mcause", dut.csr[12'h342], 32'd0);
        check("rst2_mem_kept", dut.memory.m[16'h8], 32'h0000_0073);
        check_regs_zero("rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
